// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
//   NCH independent pulse-train channels. A start strobe captures the
//   channel's timing fields into shadow registers, waits `delay` cycles, then
//   emits pulses `width` cycles high out of every `period` cycles. Bursts of
//   `count` periods end with a one-cycle done strobe. A count of 0 runs until
//   stop or rst.
//
// Ports
//   clk     system clock, all logic on posedge
//   rst     asynchronous active-high reset
//   start   [NCH]      per-channel start strobe (ignored while busy)
//   stop    [NCH]      per-channel abort strobe (wins over start)
//   period  [NCH*CW]   period in cycles, channel i at [i*CW +: CW] (0 -> 1)
//   width   [NCH*CW]   high time in cycles
//   delay   [NCH*CW]   cycles from start to first rising edge
//   count   [NCH*16]   periods per burst, 0 = continuous
//   pulse   [NCH]      registered pulse outputs
//   busy    [NCH]      channel in DELAY or RUN
//   done    [NCH]      one-cycle strobe during the last cycle of a finite burst
// ---------------------------------------------------------------------------
module pulse_train_gen #(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH*CW-1:0] period,
  input  logic [NCH*CW-1:0] width,
  input  logic [NCH*CW-1:0] delay,
  input  logic [NCH*16-1:0] count,
  output logic [NCH-1:0]    pulse,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN} state_t;

  // Pulse counter must hold any 16-bit count value even when CW is narrow.
  localparam int NW = (CW > 16) ? CW : 16;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t          state;
    logic [CW-1:0]   sh_p, sh_w, sh_d;
    logic [15:0]     sh_n;
    logic [CW-1:0]   phase, dcnt;
    logic [NW-1:0]   pcnt;
    logic            pulse_q, busy_q, done_q;

    logic [CW-1:0]   in_p, in_w, in_d, p_eff, phase_nx;
    logic [15:0]     in_n;
    logic            wrap, final_period, next_is_final;

    assign in_p  = period[i*CW +: CW];
    assign in_w  = width[i*CW +: CW];
    assign in_d  = delay[i*CW +: CW];
    assign in_n  = count[i*16 +: 16];
    assign p_eff = (in_p == '0) ? CW'(1) : in_p;

    assign phase_nx = phase + CW'(1);
    // sh_p is latched as >= 1, so sh_p - 1 never underflows.
    assign wrap          = (phase >= sh_p - CW'(1));
    // pcnt counts completed periods; the burst is in its final period when
    // pcnt == N-1, and the next period will be final when pcnt == N-2.
    assign final_period  = (sh_n != 16'd0) && (pcnt == NW'(sh_n) - NW'(1));
    assign next_is_final = (sh_n != 16'd0) && (pcnt + NW'(2) == NW'(sh_n));

    // NOTE: sequential state uses non-blocking assignments and an async reset
    // in the sensitivity list so outputs drop the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= S_IDLE;
        sh_p    <= '0;
        sh_w    <= '0;
        sh_d    <= '0;
        sh_n    <= '0;
        phase   <= '0;
        dcnt    <= '0;
        pcnt    <= '0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (state != S_IDLE && stop[i]) begin
        // Abort: no done strobe.
        state   <= S_IDLE;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            // Stop in the same cycle as start cancels it.
            if (start[i] && !stop[i]) begin
              sh_p   <= p_eff;
              sh_w   <= in_w;
              sh_d   <= in_d;
              sh_n   <= in_n;
              phase  <= '0;
              dcnt   <= '0;
              pcnt   <= '0;
              busy_q <= 1'b1;
              if (in_d != '0) begin
                state <= S_DELAY;
              end else begin
                state   <= S_RUN;
                pulse_q <= (in_w != '0);
                done_q  <= (in_n == 16'd1) && (p_eff == CW'(1));
              end
            end
          end

          S_DELAY: begin
            if (dcnt >= sh_d - CW'(1)) begin
              state   <= S_RUN;
              phase   <= '0;
              pulse_q <= (sh_w != '0);
              done_q  <= (sh_n == 16'd1) && (sh_p == CW'(1));
            end else begin
              dcnt <= dcnt + CW'(1);
            end
          end

          S_RUN: begin
            if (wrap) begin
              if (final_period) begin
                state   <= S_IDLE;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
              end else begin
                pcnt    <= pcnt + NW'(1);
                phase   <= '0;
                pulse_q <= (sh_w != '0);
                done_q  <= next_is_final && (sh_p == CW'(1));
              end
            end else begin
              phase   <= phase_nx;
              pulse_q <= (phase_nx < sh_w);
              // done is registered, so raise it on entry to the last cycle.
              done_q  <= final_period && (phase_nx == sh_p - CW'(1));
            end
          end

          default: begin
            state   <= S_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end

    assign pulse[i] = pulse_q;
    assign busy[i]  = busy_q;
    assign done[i]  = done_q;
  end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter NCH, default 4, number of independent pulse channels (1..16).
REQ-002 Parameter CW, default 32, width of each timing field and counter.
REQ-003 Reset rst, asynchronous, active-high; clock clk.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  NCH  per-channel start strobe, one clk wide, sampled on posedge.
REQ-007 stop  input  NCH  per-channel abort strobe.
REQ-008 period  input  NCH*CW  per-channel period in clk cycles; channel i at [i*CW +: CW].
REQ-009 width  input  NCH*CW  per-channel high time in clk cycles.
REQ-010 delay  input  NCH*CW  per-channel cycles from start to first rising edge.
REQ-011 count  input  NCH*16  per-channel pulse count; 0 means continuous.
REQ-012 pulse  output  NCH  registered pulse outputs.
REQ-013 busy  output  NCH  high while a channel is in DELAY or RUN.
REQ-014 done  output  NCH  one-cycle strobe when a finite burst completes.

Function
REQ-015 Each channel SHALL run an independent FSM: IDLE, DELAY, RUN.
REQ-016 In IDLE, a start strobe SHALL latch period, width, delay, count into channel shadow registers; later input changes SHALL NOT affect the running burst.
REQ-017 From IDLE, start SHALL enter DELAY if latched delay>0, else RUN directly.
REQ-018 In DELAY, the channel SHALL count delay cycles, then enter RUN; pulse SHALL stay 0.
REQ-019 With delay=0, pulse SHALL be 1 in the cycle after the start edge (latency 1 clk); with delay=D, in the cycle D+1 after the start edge.
REQ-020 In RUN, a phase counter SHALL step 0..P-1 and wrap, with pulse=1 while phase<W and 0 otherwise, P and W being the latched values.
REQ-021 Latched period 0 SHALL be treated as 1.
REQ-022 W=0 SHALL hold pulse at 0 while periods are still counted; W>=P SHALL hold pulse at 1 for the whole burst.
REQ-023 Each phase wrap SHALL increment a pulse counter; when it reaches a nonzero latched count, the FSM SHALL return to IDLE, pulse SHALL go 0, and done SHALL strobe for exactly one cycle.
REQ-024 Latched count 0 SHALL run RUN indefinitely until stop or rst.
REQ-025 A start while busy SHALL be ignored; no re-latch, no restart.
REQ-026 stop SHALL force IDLE on the next posedge with pulse=0 and busy=0; done SHALL NOT strobe.
REQ-027 Simultaneous start and stop on a channel SHALL resolve to stop.
REQ-028 stop in IDLE SHALL have no effect.
REQ-029 The final pulse of a finite burst SHALL have full width W; done SHALL assert in the cycle the last period ends.
REQ-030 busy SHALL be 1 from the cycle after start through the last RUN cycle inclusive.
REQ-031 Counters SHALL be CW bits; the comparison phase>=P-1 SHALL use the latched P (>=1), so underflow cannot occur.
REQ-032 Channels SHALL share no state; activity on one channel SHALL NOT alter timing on another.

Reset
REQ-033 rst SHALL asynchronously set all FSMs to IDLE and clear pulse, busy, done, all counters, and all shadow registers to 0.
REQ-034 rst asserted mid-burst SHALL drop pulse within the same cycle; after release, a channel SHALL require a new start.

Verification
REQ-035 Ch0 P=5 W=2 D=0 N=3, start at cycle 0 -> pulse high cycles 1-2, 6-7, 11-12; done at cycle 15; busy cycles 1-15.
REQ-036 Ch1 P=4 W=1 D=3 N=0 -> first high at cycle 4, then every 4 cycles; stop at cycle 20 -> pulse and busy 0 from cycle 21, no done.
REQ-037 Edge widths: P=0 W=0 N=2 -> pulse never high, done after 2 cycles; P=3 W=7 N=2 -> pulse high 6 consecutive cycles, then done.
REQ-038 Ch0 running, start retoggled with new period -> timing unchanged; change period input mid-burst -> no effect.
REQ-039 All NCH channels started in the same cycle with distinct settings -> each matches its own expected waveform; stop on ch2 leaves the others undisturbed.
REQ-040 rst pulsed mid-burst -> all outputs 0 immediately; start after release -> clean burst from phase 0.
